// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one block-RAM port.
// One transaction is in flight at a time: IDLE -> ISSUE -> (WAIT) -> DONE.
// All outputs are flops whose next values are computed together with the next state.
module mem_port_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Wide enough for RD_LAT-1 with RD_LAT up to 4.
  localparam int CNT_W = 2;

  state_t             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_l_q, we_l_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;
  logic               mem_we_q, mem_we_d;
  logic               busy_q, busy_d;
  logic               grant_id_q, grant_id_d;

  logic               win;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) win = ~rr_last_q;
    else if (req1)    win = 1'b1;
  end

  assign win_we    = win ? we1    : we0;
  assign win_addr  = win ? addr1  : addr0;
  assign win_wdata = win ? wdata1 : wdata0;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    we_l_d     = we_l_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = mem_we_q;
    grant_id_d = grant_id_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant_id_d = win;
          rr_last_d  = win;
          we_l_d     = win_we;
          mem_addr_d = win_addr;
          mem_we_d   = win_we;
          mem_din_d  = win_we ? win_wdata : '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_we_d  = 1'b0;
        mem_din_d = '0;
        if (we_l_q) begin
          // Write was taken by memory on this edge; acknowledge next cycle.
          mem_addr_d = '0;
          ack0_d     = ~grant_id_q;
          ack1_d     = grant_id_q;
          state_d    = S_DONE;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (grant_id_q) rdata1_d = mem_dout;
          else            rdata0_d = mem_dout;
          mem_addr_d = '0;
          ack0_d     = ~grant_id_q;
          ack1_d     = grant_id_q;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q    <= S_IDLE;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      we_l_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      grant_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      we_l_q     <= we_l_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle-by-cycle vector table on an RD_LAT=1 instance,
// plus a hand-written reset-during-read sequence on an RD_LAT=3 instance.
module tb_mem_port_arbiter;

  typedef struct {
    logic        rst;
    logic        req0, we0;
    logic [23:0] addr0;
    logic [15:0] wd0;
    logic        req1, we1;
    logic [23:0] addr1;
    logic [15:0] wd1;
    logic        ack0, ack1, mwe;
    logic [23:0] maddr;
    logic [15:0] mdin;
    logic        busy, gid;
    logic [15:0] rd0, rd1;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- instance A: RD_LAT = 1 ----------------
  logic        reset_a = 1'b1;
  logic        req0_a = 0, we0_a = 0, req1_a = 0, we1_a = 0;
  logic [23:0] addr0_a = 0, addr1_a = 0;
  logic [15:0] wdata0_a = 0, wdata1_a = 0;
  logic        ack0_a, ack1_a, mem_we_a, busy_a, gid_a;
  logic [15:0] rdata0_a, rdata1_a, mem_din_a, mem_dout_a;
  logic [23:0] mem_addr_a;

  mem_port_arbiter #(.ADDR_W(24), .DATA_W(16), .RD_LAT(1)) u_dut_a (
    .clock(clock), .reset(reset_a),
    .req0(req0_a), .we0(we0_a), .addr0(addr0_a), .wdata0(wdata0_a), .ack0(ack0_a), .rdata0(rdata0_a),
    .req1(req1_a), .we1(we1_a), .addr1(addr1_a), .wdata1(wdata1_a), .ack1(ack1_a), .rdata1(rdata1_a),
    .mem_addr(mem_addr_a), .mem_din(mem_din_a), .mem_we(mem_we_a), .mem_dout(mem_dout_a),
    .busy(busy_a), .grant_id(gid_a)
  );

  // Block-RAM model, one cycle read latency.
  logic [15:0] mem_a [256];
  logic [15:0] pa;
  always @(posedge clock) begin
    if (mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_din_a;
    pa <= mem_a[mem_addr_a[7:0]];
  end
  assign mem_dout_a = pa;

  // ---------------- instance B: RD_LAT = 3 ----------------
  logic        reset_b = 1'b1;
  logic        req1_b = 0;
  logic [23:0] addr1_b = 0;
  logic        ack0_b, ack1_b, mem_we_b, busy_b, gid_b;
  logic [15:0] rdata0_b, rdata1_b, mem_din_b, mem_dout_b;
  logic [23:0] mem_addr_b;

  mem_port_arbiter #(.ADDR_W(24), .DATA_W(16), .RD_LAT(3)) u_dut_b (
    .clock(clock), .reset(reset_b),
    .req0(1'b0), .we0(1'b0), .addr0(24'h0), .wdata0(16'h0), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1_b), .we1(1'b0), .addr1(addr1_b), .wdata1(16'h0), .ack1(ack1_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_din(mem_din_b), .mem_we(mem_we_b), .mem_dout(mem_dout_b),
    .busy(busy_b), .grant_id(gid_b)
  );

  // Block-RAM model, three cycle read latency.
  logic [15:0] mem_b [256];
  logic [15:0] pb0, pb1, pb2;
  always @(posedge clock) begin
    if (mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_din_b;
    pb0 <= mem_b[mem_addr_b[7:0]];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mem_dout_b = pb2;

  // ---------------- helpers ----------------
  vec_t vecs[$];

  task automatic add(input logic rst,
                     input logic rq0, input logic w0, input logic [23:0] a0, input logic [15:0] d0,
                     input logic rq1, input logic w1, input logic [23:0] a1, input logic [15:0] d1,
                     input logic k0, input logic k1, input logic mwe, input logic [23:0] maddr,
                     input logic [15:0] mdin, input logic bsy, input logic gid,
                     input logic [15:0] r0, input logic [15:0] r1);
    vec_t v;
    v.rst = rst;
    v.req0 = rq0; v.we0 = w0; v.addr0 = a0; v.wd0 = d0;
    v.req1 = rq1; v.we1 = w1; v.addr1 = a1; v.wd1 = d1;
    v.ack0 = k0; v.ack1 = k1; v.mwe = mwe; v.maddr = maddr; v.mdin = mdin;
    v.busy = bsy; v.gid = gid; v.rd0 = r0; v.rd1 = r1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [76:0] act, input logic [76:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got {ack0,ack1,we,addr,din,busy,gid,rd0,rd1}=%h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [76:0] pack_a();
    return {ack0_a, ack1_a, mem_we_a, mem_addr_a, mem_din_a, busy_a, gid_a, rdata0_a, rdata1_a};
  endfunction

  function automatic logic [76:0] pack_b();
    return {ack0_b, ack1_b, mem_we_b, mem_addr_b, mem_din_b, busy_b, gid_b, rdata0_b, rdata1_b};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 16'h0;
      mem_b[i] = 16'h0;
    end
    mem_a[1] = 16'h00A1; mem_a[2] = 16'h00A2; mem_a[3] = 16'h00A3;
    mem_b[5] = 16'h5555;

    // Each row: inputs held across one rising edge, outputs expected just after it.
    // Reset held 3 cycles with both requesters asserting writes.
    for (int i = 0; i < 3; i++)
      add(1, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 0,0,0,24'h0,16'h0,0,0,16'h0,16'h0);
    // Both held: grants alternate 0,1,0,1 starting with port 0.
    for (int k = 0; k < 2; k++) begin
      add(0, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 0,0,1,24'h20,16'h1111,1,0,16'h0,16'h0);
      add(0, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 1,0,0,24'h0,16'h0,1,0,16'h0,16'h0);
      add(0, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 0,0,0,24'h0,16'h0,0,0,16'h0,16'h0);
      add(0, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 0,0,1,24'h30,16'h2222,1,1,16'h0,16'h0);
      add(0, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 0,1,0,24'h0,16'h0,1,1,16'h0,16'h0);
      if (k == 0)
        add(0, 1,1,24'h20,16'h1111, 1,1,24'h30,16'h2222, 0,0,0,24'h0,16'h0,0,1,16'h0,16'h0);
    end
    add(0, 0,0,24'h0,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h0,16'h0,0,1,16'h0,16'h0);
    // Port-0 write 0x10 <= 0xBEEF: mem_we in cycle 1 only, ack0 in cycle 2.
    add(0, 1,1,24'h10,16'hBEEF, 0,0,24'h0,16'h0, 0,0,1,24'h10,16'hBEEF,1,0,16'h0,16'h0);
    add(0, 1,1,24'h10,16'hBEEF, 0,0,24'h0,16'h0, 1,0,0,24'h0,16'h0,1,0,16'h0,16'h0);
    add(0, 0,0,24'h0,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h0,16'h0,0,0,16'h0,16'h0);
    add(0, 0,0,24'h0,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h0,16'h0,0,0,16'h0,16'h0);
    // Port-0 read 0x10: ack0 with rdata0 = 0xBEEF in cycle 3.
    add(0, 1,0,24'h10,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h10,16'h0,1,0,16'h0,16'h0);
    add(0, 1,0,24'h10,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h10,16'h0,1,0,16'h0,16'h0);
    add(0, 1,0,24'h10,16'h0, 0,0,24'h0,16'h0, 1,0,0,24'h0,16'h0,1,0,16'hBEEF,16'h0);
    add(0, 0,0,24'h0,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h0,16'h0,0,0,16'hBEEF,16'h0);
    // Port-1 back-to-back reads of 1,2,3 with req1 held high.
    for (int a = 1; a <= 3; a++) begin
      add(0, 0,0,24'h0,16'h0, 1,0,24'(a),16'h0, 0,0,0,24'(a),16'h0,1,1,16'hBEEF,16'(a - 1 + 16'hA0) & {16{a != 1}});
      add(0, 0,0,24'h0,16'h0, 1,0,24'(a),16'h0, 0,0,0,24'(a),16'h0,1,1,16'hBEEF,16'(a - 1 + 16'hA0) & {16{a != 1}});
      add(0, 0,0,24'h0,16'h0, 1,0,24'(a),16'h0, 0,1,0,24'h0,16'h0,1,1,16'hBEEF,16'(a + 16'hA0));
      if (a < 3)
        add(0, 0,0,24'h0,16'h0, 1,0,24'(a + 1),16'h0, 0,0,0,24'h0,16'h0,0,1,16'hBEEF,16'(a + 16'hA0));
    end
    add(0, 0,0,24'h0,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h0,16'h0,0,1,16'hBEEF,16'h00A3);
    // Port-1 write leaves both read registers untouched.
    add(0, 0,0,24'h0,16'h0, 1,1,24'h40,16'h7777, 0,0,1,24'h40,16'h7777,1,1,16'hBEEF,16'h00A3);
    add(0, 0,0,24'h0,16'h0, 1,1,24'h40,16'h7777, 0,1,0,24'h0,16'h0,1,1,16'hBEEF,16'h00A3);
    add(0, 0,0,24'h0,16'h0, 0,0,24'h0,16'h0, 0,0,0,24'h0,16'h0,0,1,16'hBEEF,16'h00A3);

    @(negedge clock);
    foreach (vecs[i]) begin
      reset_a  = vecs[i].rst;
      req0_a   = vecs[i].req0; we0_a = vecs[i].we0; addr0_a = vecs[i].addr0; wdata0_a = vecs[i].wd0;
      req1_a   = vecs[i].req1; we1_a = vecs[i].we1; addr1_a = vecs[i].addr1; wdata1_a = vecs[i].wd1;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), pack_a(),
            {vecs[i].ack0, vecs[i].ack1, vecs[i].mwe, vecs[i].maddr, vecs[i].mdin,
             vecs[i].busy, vecs[i].gid, vecs[i].rd0, vecs[i].rd1});
    end

    // RD_LAT=3 port-1 read interrupted by reset in the second WAIT cycle.
    reset_b = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_b = 1'b0; req1_b = 1'b1; addr1_b = 24'h5;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      check($sformatf("lat3_pre_reset_c%0d", c), pack_b(), {1'b0,1'b0,1'b0,24'h5,16'h0,1'b1,1'b1,16'h0,16'h0});
    end
    reset_b = 1'b1;
    @(posedge clock); #1;
    check("lat3_reset_in_wait", pack_b(), 77'h0);
    reset_b = 1'b0;
    // Following read completes: ISSUE + 3 WAIT cycles, then ack1 in cycle 2+RD_LAT.
    for (int c = 0; c < 4; c++) begin
      @(posedge clock); #1;
      check($sformatf("lat3_read_c%0d", c), pack_b(), {1'b0,1'b0,1'b0,24'h5,16'h0,1'b1,1'b1,16'h0,16'h0});
    end
    @(posedge clock); #1;
    check("lat3_read_ack", pack_b(), {1'b0,1'b1,1'b0,24'h0,16'h0,1'b1,1'b1,16'h0,16'h5555});
    req1_b = 1'b0;
    @(posedge clock); #1;
    check("lat3_idle_after", pack_b(), {1'b0,1'b0,1'b0,24'h0,16'h0,1'b0,1'b1,16'h0,16'h5555});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
